// File: rtl/wb_crossbar_pkg.sv
// Shared types and helpers for the Wishbone crossbar slave-side arbitration stage.
package wb_crossbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
    function automatic int tmo_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Per-slave round-robin arbiter: grants one master, locks it for the bus cycle,
// and force-releases the slave through a watchdog when it never responds.
module wb_rr_arbiter
    import wb_crossbar_pkg::*;
#(
    parameter int NM      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [NM-1:0] i_req,
    input  logic [NM-1:0] i_cyc,
    input  logic [NM-1:0] i_stb,
    input  logic          i_resp,
    output logic [NM-1:0] o_grant,
    output logic [NM-1:0] o_timeout
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = tmo_cnt_width(TIMEOUT);
    localparam logic [PW-1:0] PTR_RST = PW'(NM - 1);

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NM-1:0]  grant_q, grant_d;
    logic [NM-1:0]  timeout_q, timeout_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           found;
    logic [PW-1:0]  winner;
    int             cand;
    logic           owner_cyc;
    logic           owner_stb;

    // The pointer doubles as the owner index while BUSY/HOLD.
    assign owner_cyc = i_cyc[ptr_q];
    assign owner_stb = i_stb[ptr_q];

    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = 0;
        for (int i = 1; i <= NM; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NM) begin
                cand = cand - NM;
            end
            if (!found && i_req[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    ptr_d           = winner;
                    cnt_d           = '0;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                // Owner release beats the watchdog; a response beats the threshold.
                if (!owner_cyc) begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (TIMEOUT > 0) begin
                    if (i_resp || !owner_stb) begin
                        cnt_d = '0;
                    end else if (int'(cnt_q) + 1 >= TIMEOUT) begin
                        grant_d          = '0;
                        cnt_d            = '0;
                        timeout_d[ptr_q] = 1'b1;
                        state_d          = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_RST;
            grant_q   <= '0;
            timeout_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;

endmodule

// File: rtl/wb_crossbar_arbiter.sv
// Slave-side arbitration stage of the Wishbone crossbar: one round-robin
// arbiter per slave, fed by the decoder's master-to-slave request matrix.
module wb_crossbar_arbiter
    import wb_crossbar_pkg::*;
#(
    parameter int NM      = 2,
    parameter int NS      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NM-1:0]          i_cyc,
    input  logic [NM-1:0]          i_stb,
    input  logic [NM-1:0][NS-1:0]  i_requested,
    input  logic [NS-1:0]          i_slave_resp,
    output logic [NS-1:0][NM-1:0]  o_grant,
    output logic [NM-1:0]          o_granted,
    output logic [NM-1:0]          o_timeout
);

    generate
        if (NM < 1) begin : g_bad_nm
            $error("wb_crossbar_arbiter: NM must be at least 1");
        end
        if (NS < 1) begin : g_bad_ns
            $error("wb_crossbar_arbiter: NS must be at least 1");
        end
    endgenerate

    logic [NS-1:0][NM-1:0] req;
    logic [NS-1:0][NM-1:0] slave_tmo;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slave
            for (gj = 0; gj < NM; gj++) begin : g_master
                assign req[gi][gj] = i_cyc[gj] & i_stb[gj] & i_requested[gj][gi];
            end

            wb_rr_arbiter #(
                .NM      (NM),
                .TIMEOUT (TIMEOUT)
            ) u_arb (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_req     (req[gi]),
                .i_cyc     (i_cyc),
                .i_stb     (i_stb),
                .i_resp    (i_slave_resp[gi]),
                .o_grant   (o_grant[gi]),
                .o_timeout (slave_tmo[gi])
            );
        end
    endgenerate

    // Outputs are pure ORs of registered state, so no input reaches them combinationally.
    always_comb begin
        o_granted = '0;
        o_timeout = '0;
        for (int s = 0; s < NS; s++) begin
            o_granted = o_granted | o_grant[s];
            o_timeout = o_timeout | slave_tmo[s];
        end
    end

endmodule

// File: tb/tb_wb_crossbar_arbiter.sv
// Scoreboard bench for wb_crossbar_arbiter (NM=2, NS=2, TIMEOUT=4): directed
// per-cycle vectors queue their expected outputs, a negedge monitor checks them.
module tb_wb_crossbar_arbiter;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [1:0]      i_cyc;
    logic [1:0]      i_stb;
    logic [1:0][1:0] i_requested;
    logic [1:0]      i_slave_resp;
    logic [1:0][1:0] o_grant;
    logic [1:0]      o_granted;
    logic [1:0]      o_timeout;

    wb_crossbar_arbiter #(
        .NM      (2),
        .NS      (2),
        .TIMEOUT (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cyc        (i_cyc),
        .i_stb        (i_stb),
        .i_requested  (i_requested),
        .i_slave_resp (i_slave_resp),
        .o_grant      (o_grant),
        .o_granted    (o_granted),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic [1:0] granted;
        logic [1:0] tmo;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt     = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: outputs settle after the posedge, compare at the negedge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            vectors++;
            if ({o_grant} !== e.grant || o_granted !== e.granted || o_timeout !== e.tmo) begin
                miscompares++;
                $display("FAIL %s: grant=%b granted=%b timeout=%b, expected grant=%b granted=%b timeout=%b",
                         e.name, {o_grant}, o_granted, o_timeout, e.grant, e.granted, e.tmo);
            end else begin
                $display("ok   %s: grant=%b granted=%b timeout=%b", e.name, {o_grant}, o_granted, o_timeout);
            end
        end
        if (cyc_cnt > 1) begin
            for (int m = 0; m < 2; m++) begin
                vectors++;
                if (o_grant[0][m] === 1'b1 && o_grant[1][m] === 1'b1) begin
                    miscompares++;
                    $display("FAIL exclusive_grant m%0d: grant=%b, expected at most one slave", m, {o_grant});
                end
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic [1:0] cyc,
                        input logic [1:0] stb, input logic [3:0] rq, input logic [1:0] resp,
                        input logic [3:0] eg, input logic [1:0] egd, input logic [1:0] eto);
        exp_t e;
        @(posedge clk);
        #1;
        i_rst        = rst;
        i_cyc        = cyc;
        i_stb        = stb;
        i_requested  = rq;
        i_slave_resp = resp;
        e.cyc     = cyc_cnt + 1;
        e.grant   = eg;
        e.granted = egd;
        e.tmo     = eto;
        e.name    = name;
        sb.push_back(e);
    endtask

    initial begin
        i_rst = 1'b1; i_cyc = '0; i_stb = '0; i_requested = '0; i_slave_resp = '0;
        // name            rst cyc    stb    req      resp   grant    granted tmo
        step("reset0",       1, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);
        step("reset1",       1, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);
        step("idle",         0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);
        // m0 -> s1 single request
        step("single_grant", 0, 2'b01, 2'b01, 4'b0010, 2'b11, 4'b0100, 2'b01, 2'b00);
        for (int k = 0; k < 3; k++)
            step("single_hold", 0, 2'b01, 2'b01, 4'b0010, 2'b11, 4'b0100, 2'b01, 2'b00);
        step("single_rel",   0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0000, 2'b00, 2'b00);
        step("single_idle",  0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0000, 2'b00, 2'b00);
        // round-robin on s0
        for (int k = 0; k < 3; k++)
            step("rr_m0", 0, 2'b11, 2'b11, 4'b0101, 2'b11, 4'b0001, 2'b01, 2'b00);
        step("rr_turn0",     0, 2'b10, 2'b10, 4'b0101, 2'b11, 4'b0000, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++)
            step("rr_m1", 0, 2'b11, 2'b11, 4'b0101, 2'b11, 4'b0010, 2'b10, 2'b00);
        step("rr_turn1",     0, 2'b01, 2'b01, 4'b0101, 2'b11, 4'b0000, 2'b00, 2'b00);
        step("rr_m0_again",  0, 2'b11, 2'b11, 4'b0101, 2'b11, 4'b0001, 2'b01, 2'b00);
        step("rr_end",       0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0000, 2'b00, 2'b00);
        // bus lock: m1 owns s0, stb drops, m0 requests
        step("lock_grant",   0, 2'b10, 2'b10, 4'b0100, 2'b11, 4'b0010, 2'b10, 2'b00);
        for (int k = 0; k < 3; k++)
            step("lock_hold", 0, 2'b11, 2'b01, 4'b0101, 2'b11, 4'b0010, 2'b10, 2'b00);
        step("lock_rel",     0, 2'b01, 2'b01, 4'b0001, 2'b11, 4'b0000, 2'b00, 2'b00);
        step("lock_m0",      0, 2'b01, 2'b01, 4'b0001, 2'b11, 4'b0001, 2'b01, 2'b00);
        step("lock_end",     0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0000, 2'b00, 2'b00);
        // parallel grants m0->s0, m1->s1
        step("par_grant",    0, 2'b11, 2'b11, 4'b1001, 2'b11, 4'b1001, 2'b11, 2'b00);
        step("par_hold",     0, 2'b11, 2'b11, 4'b1001, 2'b11, 4'b1001, 2'b11, 2'b00);
        step("par_end",      0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0000, 2'b00, 2'b00);
        // watchdog: m0 strobes s1 with no response, m1 waits for s1
        step("tmo_grant",    0, 2'b11, 2'b11, 4'b1010, 2'b00, 4'b0100, 2'b01, 2'b00);
        for (int k = 0; k < 3; k++)
            step("tmo_count", 0, 2'b11, 2'b11, 4'b1010, 2'b00, 4'b0100, 2'b01, 2'b00);
        step("tmo_fire",     0, 2'b11, 2'b11, 4'b1010, 2'b00, 4'b0000, 2'b00, 2'b01);
        for (int k = 0; k < 2; k++)
            step("tmo_hold", 0, 2'b11, 2'b11, 4'b1010, 2'b00, 4'b0000, 2'b00, 2'b00);
        step("tmo_drop",     0, 2'b10, 2'b10, 4'b1010, 2'b00, 4'b0000, 2'b00, 2'b00);
        step("tmo_m1",       0, 2'b10, 2'b10, 4'b1010, 2'b00, 4'b1000, 2'b10, 2'b00);
        step("tmo_end",      0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);
        // response on the threshold cycle, then cyc drop on the threshold cycle
        step("rsp_grant",    0, 2'b01, 2'b01, 4'b0010, 2'b00, 4'b0100, 2'b01, 2'b00);
        for (int k = 0; k < 3; k++)
            step("rsp_count", 0, 2'b01, 2'b01, 4'b0010, 2'b00, 4'b0100, 2'b01, 2'b00);
        step("rsp_at_thr",   0, 2'b01, 2'b01, 4'b0010, 2'b10, 4'b0100, 2'b01, 2'b00);
        for (int k = 0; k < 3; k++)
            step("rsp_recount", 0, 2'b01, 2'b01, 4'b0010, 2'b00, 4'b0100, 2'b01, 2'b00);
        step("cyc_at_thr",   0, 2'b00, 2'b01, 4'b0010, 2'b00, 4'b0000, 2'b00, 2'b00);
        step("cyc_idle",     0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);
        // reset while BUSY, then pointer back to master-0 priority
        step("rst_busy_grant", 0, 2'b11, 2'b11, 4'b1001, 2'b11, 4'b1001, 2'b11, 2'b00);
        step("rst_busy",     1, 2'b11, 2'b11, 4'b1001, 2'b11, 4'b0000, 2'b00, 2'b00);
        step("rst_ptr",      0, 2'b11, 2'b11, 4'b0101, 2'b11, 4'b0001, 2'b01, 2'b00);
        step("rst_end",      0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0000, 2'b00, 2'b00);
        // simultaneous timeouts to different masters
        step("dual_grant",   0, 2'b11, 2'b11, 4'b1001, 2'b00, 4'b1001, 2'b11, 2'b00);
        for (int k = 0; k < 3; k++)
            step("dual_count", 0, 2'b11, 2'b11, 4'b1001, 2'b00, 4'b1001, 2'b11, 2'b00);
        step("dual_fire",    0, 2'b11, 2'b11, 4'b1001, 2'b00, 4'b0000, 2'b00, 2'b11);
        step("dual_drop",    0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);
        step("dual_idle",    0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00);

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
